// File: rtl/axil_led_pkg.sv
// axil_led_pkg: register offsets, response codes, CTRL bits and FSM states for the LED blinker.
package axil_led_pkg;
   localparam logic [4:0] ADDR_CTRL         = 5'h00;
   localparam logic [4:0] ADDR_HALF_PERIOD  = 5'h04;
   localparam logic [4:0] ADDR_LED_MASK     = 5'h08;
   localparam logic [4:0] ADDR_TOGGLE_COUNT = 5'h0C;
   localparam logic [4:0] ADDR_ID           = 5'h10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int CTRL_EN  = 0;
   localparam int CTRL_INV = 1;
   typedef enum logic [1:0] {W_INIT, W_IDLE, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} rd_state_t;
   function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] data,
                                              input logic [3:0] strb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? data[8*i +: 8] : cur[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/axil_led_blinker_if.sv
// axil_led_blinker_if: AXI4-Lite bus bundle with master and slave views.
interface axil_led_blinker_if #(parameter int ADDR_W = 40);
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid, awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid, wready;
   logic [1:0]        bresp;
   logic              bvalid, bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid, arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid, rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_led_blinker_blink_engine.sv
// blink_engine: half-period counter that toggles a phase, counts toggles and drives the masked LEDs.
module blink_engine #(
   parameter int N_LEDS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              invert,
   input  logic [31:0]       half_period,
   input  logic [N_LEDS-1:0] mask,
   input  logic              clr_count,
   output logic [N_LEDS-1:0] led,
   output logic [31:0]       toggle_count
);
   logic [31:0] cnt, cnt_last;
   logic        phase, wrap;
   // a half-period of 0 is treated as 1; >= lets a lowered half-period take effect at once
   assign cnt_last = (half_period == '0) ? '0 : half_period - 32'd1;
   assign wrap     = enable && (cnt >= cnt_last);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         phase        <= 1'b0;
         toggle_count <= '0;
         led          <= '0;
      end else begin
         cnt          <= (!enable || wrap) ? '0 : cnt + 32'd1;
         phase        <= !enable ? 1'b0 : phase ^ wrap;
         toggle_count <= clr_count ? '0 : toggle_count + {31'd0, wrap};
         led          <= (phase ^ invert) ? mask : '0;
      end
   end
endmodule

// File: rtl/axil_led_blinker.sv
// axil_led_blinker: AXI4-Lite register slave controlling an LED blink engine.
module axil_led_blinker
   import axil_led_pkg::*;
#(
   parameter int          N_LEDS              = 8,
   parameter logic [31:0] DEFAULT_HALF_PERIOD = 32'd50000000,
   parameter logic [31:0] ID_VALUE            = 32'h1ED0_B11C,
   parameter int          ADDR_W              = 40
) (
   input  logic               pl_sys_clk,
   input  logic               axil_arst_n,
   axil_led_blinker_if.slave  s_axil,
   output logic [N_LEDS-1:0]  led
);
   wr_state_t         wr_st, wr_nxt;
   rd_state_t         rd_st, rd_nxt;
   logic              aw_held, w_held, aw_hs, w_hs, ar_hs, do_write, clr_count, en, inv;
   logic [2:0]        aw_idx, wr_idx;
   logic [31:0]       w_data, wr_data, wr_val, half_period, toggle_count;
   logic [3:0]        w_strb, wr_strb;
   logic [N_LEDS-1:0] mask;
   logic [31:0]       view [8];
   logic              unused_ok;
   assign unused_ok = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[ADDR_W-1:5], s_axil.awaddr[1:0],
                        s_axil.araddr[ADDR_W-1:5], s_axil.araddr[1:0]};
   assign s_axil.awready = (wr_st == W_IDLE) && !aw_held;
   assign s_axil.wready  = (wr_st == W_IDLE) && !w_held;
   assign s_axil.bvalid  = (wr_st == W_RESP);
   assign s_axil.arready = (rd_st == R_IDLE);
   assign s_axil.rvalid  = (rd_st == R_DATA);
   assign aw_hs     = s_axil.awvalid && s_axil.awready;
   assign w_hs      = s_axil.wvalid && s_axil.wready;
   assign ar_hs     = s_axil.arvalid && s_axil.arready;
   assign do_write  = (aw_held || aw_hs) && (w_held || w_hs);
   assign wr_idx    = aw_hs ? s_axil.awaddr[4:2] : aw_idx;
   assign wr_data   = w_hs ? s_axil.wdata : w_data;
   assign wr_strb   = w_hs ? s_axil.wstrb : w_strb;
   assign wr_val    = apply_strb(view[wr_idx], wr_data, wr_strb);
   assign clr_count = do_write && (wr_idx == ADDR_TOGGLE_COUNT[4:2]);
   always_comb begin
      view                                = '{default: '0};
      view[ADDR_CTRL[4:2]][CTRL_EN]       = en;
      view[ADDR_CTRL[4:2]][CTRL_INV]      = inv;
      view[ADDR_HALF_PERIOD[4:2]]         = half_period;
      view[ADDR_LED_MASK[4:2]]            = 32'(mask);
      view[ADDR_TOGGLE_COUNT[4:2]]        = toggle_count;
      view[ADDR_ID[4:2]]                  = ID_VALUE;
   end
   always_comb begin
      wr_nxt = wr_st;
      rd_nxt = rd_st;
      wr_nxt = (wr_st == W_INIT) ? W_IDLE :
               (wr_st == W_IDLE) ? (do_write ? W_RESP : W_IDLE) :
               (s_axil.bready ? W_IDLE : W_RESP);
      rd_nxt = (rd_st == R_INIT) ? R_IDLE :
               (rd_st == R_IDLE) ? (s_axil.arvalid ? R_DATA : R_IDLE) :
               (s_axil.rready ? R_IDLE : R_DATA);
   end
   always_ff @(posedge pl_sys_clk or negedge axil_arst_n) begin
      if (!axil_arst_n) begin
         wr_st         <= W_INIT;
         rd_st         <= R_INIT;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         aw_idx        <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         s_axil.bresp  <= RESP_OKAY;
         s_axil.rdata  <= '0;
         s_axil.rresp  <= RESP_OKAY;
         en            <= 1'b0;
         inv           <= 1'b0;
         half_period   <= DEFAULT_HALF_PERIOD;
         mask          <= '1;
      end else begin
         wr_st   <= wr_nxt;
         rd_st   <= rd_nxt;
         aw_held <= (aw_held || aw_hs) && !do_write;
         w_held  <= (w_held || w_hs) && !do_write;
         if (aw_hs) aw_idx <= s_axil.awaddr[4:2];
         if (w_hs) begin
            w_data <= s_axil.wdata;
            w_strb <= s_axil.wstrb;
         end
         if (do_write) begin
            s_axil.bresp <= (wr_idx <= ADDR_ID[4:2]) ? RESP_OKAY : RESP_SLVERR;
            if (wr_idx == ADDR_CTRL[4:2]) begin
               en  <= wr_val[CTRL_EN];
               inv <= wr_val[CTRL_INV];
            end
            if (wr_idx == ADDR_HALF_PERIOD[4:2]) half_period <= wr_val;
            if (wr_idx == ADDR_LED_MASK[4:2]) mask <= wr_val[N_LEDS-1:0];
         end
         if (ar_hs) begin
            s_axil.rdata <= view[s_axil.araddr[4:2]];
            s_axil.rresp <= (s_axil.araddr[4:2] <= ADDR_ID[4:2]) ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end
   blink_engine #(.N_LEDS(N_LEDS)) u_blink (
      .clk          (pl_sys_clk),
      .rst_n        (axil_arst_n),
      .enable       (en),
      .invert       (inv),
      .half_period  (half_period),
      .mask         (mask),
      .clr_count    (clr_count),
      .led          (led),
      .toggle_count (toggle_count)
   );
endmodule
